// File: rtl/wb_arbiter_pkg.sv
// Shared core definitions for the write-back arbiter: requester count,
// requester index constants and the per-requester write-request payload.
package wb_arbiter_pkg;

    localparam int WB_NUM_REQ = 3;

    localparam int REQ_ALU = 0;
    localparam int REQ_FPU = 1;
    localparam int REQ_MEM = 2;

    typedef struct packed {
        logic [4:0]  rd;
        logic        is_freg;
        logic [31:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// Round-robin priority search: the first valid requester after last_grant
// (wrapping modulo NUM_REQ) wins; purely combinational.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    int w_cand;

    // NOTE: every output gets a default before the search loop, so no latch is inferred.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_cand = (int'(i_last_grant) + off) % NUM_REQ;
            if (!o_any && i_valid[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = IDX_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: grants one requester per cycle round-robin and drives
// the integer/float register-file write port one cycle after the grant.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = WB_NUM_REQ,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enabled,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*5-1:0]  req_rd,
    input  logic [NUM_REQ-1:0]    req_is_freg,
    input  logic [NUM_REQ*32-1:0] req_data,
    output logic                  reg_w_enable,
    output logic                  freg_w_enable,
    output logic [4:0]            reg_w_dest,
    output logic [31:0]           reg_w_data,
    output logic                  completed,
    output logic [1:0]            completed_id,
    output logic [CNT_W-1:0]      conflict_cnt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    wb_req_t              w_req [NUM_REQ];
    wb_req_t              w_win;
    logic [NUM_REQ-1:0]   w_valid_eff;
    logic [NUM_REQ-1:0]   w_grant;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_any;
    logic                 w_contended;

    logic [IDX_W-1:0]     r_last_grant;
    logic                 r_wr_valid;
    logic                 r_is_freg;
    logic [4:0]           r_rd;
    logic [31:0]          r_data;
    logic [IDX_W-1:0]     r_id;
    logic [CNT_W-1:0]     r_cnt;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_req[gi].rd      = req_rd[gi*5 +: 5];
        assign w_req[gi].is_freg = req_is_freg[gi];
        assign w_req[gi].data    = req_data[gi*32 +: 32];
    end

    // Reset is folded in so nothing is granted while rstn is held low.
    assign w_valid_eff = req_valid & {NUM_REQ{enabled & rstn}};
    assign w_contended = enabled && ($countones(req_valid) > 1);

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_valid      (w_valid_eff),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_idx        (w_idx),
        .o_any        (w_any)
    );

    assign req_ready = w_grant;
    assign w_win     = w_req[w_idx];

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_wr_valid   <= 1'b0;
            r_is_freg    <= 1'b0;
            r_rd         <= '0;
            r_data       <= '0;
            r_id         <= '0;
            r_cnt        <= '0;
        end else begin
            r_wr_valid <= w_any;
            if (w_any) begin
                r_last_grant <= w_idx;
                r_is_freg    <= w_win.is_freg;
                r_rd         <= w_win.rd;
                r_data       <= w_win.data;
                r_id         <= w_idx;
            end
            if (w_contended && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Writes to x0 retire (completed) without touching the integer file.
    assign reg_w_enable  = r_wr_valid && !r_is_freg && (r_rd != 5'd0);
    assign freg_w_enable = r_wr_valid && r_is_freg;
    assign reg_w_dest    = r_rd;
    assign reg_w_data    = r_data;
    assign completed     = r_wr_valid;
    assign completed_id  = 2'(r_id);
    assign conflict_cnt  = r_cnt;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: stimulus pushes expected retirements from a
// round-robin reference model, a monitor pops and compares after each edge.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int N = 3;

    logic            clk = 1'b0;
    logic            rstn;
    logic            enabled = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready, d2_ready;
    logic [N*5-1:0]  req_rd = '0;
    logic [N-1:0]    req_is_freg = '0;
    logic [N*32-1:0] req_data = '0;
    logic            reg_w_enable, freg_w_enable, completed;
    logic [4:0]      reg_w_dest;
    logic [31:0]     reg_w_data;
    logic [1:0]      completed_id;
    logic [15:0]     conflict_cnt;
    logic            d2_wen, d2_fwen, d2_comp;
    logic [4:0]      d2_dest;
    logic [31:0]     d2_data;
    logic [1:0]      d2_id;
    logic [1:0]      d2_cnt;

    always #5 clk = ~clk;

    wb_arbiter #(.NUM_REQ(N), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .enabled(enabled), .req_valid(req_valid),
        .req_ready(req_ready), .req_rd(req_rd), .req_is_freg(req_is_freg),
        .req_data(req_data), .reg_w_enable(reg_w_enable),
        .freg_w_enable(freg_w_enable), .reg_w_dest(reg_w_dest),
        .reg_w_data(reg_w_data), .completed(completed),
        .completed_id(completed_id), .conflict_cnt(conflict_cnt)
    );

    wb_arbiter #(.NUM_REQ(N), .CNT_W(2)) dut_c2 (
        .clk(clk), .rstn(rstn), .enabled(enabled), .req_valid(req_valid),
        .req_ready(d2_ready), .req_rd(req_rd), .req_is_freg(req_is_freg),
        .req_data(req_data), .reg_w_enable(d2_wen),
        .freg_w_enable(d2_fwen), .reg_w_dest(d2_dest),
        .reg_w_data(d2_data), .completed(d2_comp),
        .completed_id(d2_id), .conflict_cnt(d2_cnt)
    );

    typedef struct {
        int          id;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        f;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          m_last = N - 1;
    longint      m_cnt = 0;
    logic [4:0]  p_rd[N];
    logic [31:0] p_data[N];
    logic        p_f[N];
    int          last_win;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint c, input longint mx);
        return (c > mx) ? mx : c;
    endfunction

    // One cycle of stimulus; the model decides the winner from the stated rules.
    task automatic drive_cycle(input logic en, input logic [N-1:0] v);
        int win;
        int c;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        enabled   = en;
        req_valid = v;
        for (int i = 0; i < N; i++) begin
            req_rd[i*5 +: 5]    = p_rd[i];
            req_data[i*32 +: 32] = p_data[i];
            req_is_freg[i]      = p_f[i];
        end
        #1;
        win = -1;
        if (en && rstn) begin
            for (int off = 1; off <= N; off++) begin
                c = (m_last + off) % N;
                if (win < 0 && v[c]) win = c;
            end
        end
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        if (win >= 0) begin
            sb.push_back('{win, p_rd[win], p_data[win], p_f[win]});
            m_last = win;
        end
        if (en && rstn && $countones(v) >= 2) m_cnt++;
        last_win = win;
    endtask

    task automatic model_reset();
        sb.delete();
        m_last = N - 1;
        m_cnt  = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        enabled = 1'b0;
        req_valid = '0;
        model_reset();
        #1;
        check("rst_completed", 64'(completed), 64'd0);
        check("rst_dest_data", {27'd0, reg_w_dest, reg_w_data}, 64'd0);
        check("rst_cnt", 64'(conflict_cnt), 64'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rstn = 1'b1;
    endtask

    // Monitor: one expected retirement per grant, exactly one cycle later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("completed", 64'(completed), 64'd1);
                check("completed_id", 64'(completed_id), 64'(e.id));
                check("dest", 64'(reg_w_dest), 64'(e.rd));
                check("data", 64'(reg_w_data), 64'(e.data));
                check("reg_w_enable", 64'(reg_w_enable), 64'(!e.f && e.rd != 0));
                check("freg_w_enable", 64'(freg_w_enable), 64'(e.f));
            end else begin
                check("idle_completed", 64'(completed), 64'd0);
                check("idle_strobes", {62'd0, reg_w_enable, freg_w_enable}, 64'd0);
            end
            check("cnt16", 64'(conflict_cnt), 64'(sat(m_cnt, 65535)));
            check("cnt2", 64'(d2_cnt), 64'(sat(m_cnt, 3)));
        end
    end

    initial begin
        int order[6];
        int exp_order[6];
        logic [N-1:0] pend;
        exp_order = '{0, 1, 2, 0, 1, 2};
        for (int i = 0; i < N; i++) begin
            p_rd[i] = '0; p_data[i] = '0; p_f[i] = 1'b0;
        end
        rstn = 1'b1;
        #1 rstn = 1'b0;
        do_reset();

        // Single alu write.
        p_rd[REQ_ALU] = 5'd5; p_data[REQ_ALU] = 32'hDEADBEEF; p_f[REQ_ALU] = 1'b0;
        drive_cycle(1'b1, 3'b001);
        drive_cycle(1'b1, 3'b000);

        // Continuous contention after reset: strict rotation, counter 6.
        do_reset();
        for (int i = 0; i < N; i++) begin
            p_rd[i] = 5'(i + 10); p_data[i] = 32'hA000_0000 + 32'(i); p_f[i] = (i == REQ_FPU);
        end
        for (int k = 0; k < 6; k++) begin
            drive_cycle(1'b1, 3'b111);
            order[k] = last_win;
        end
        drive_cycle(1'b1, 3'b000);
        for (int k = 0; k < 6; k++) check("rr_order", 64'(order[k]), 64'(exp_order[k]));
        check("cnt_after_6", 64'(conflict_cnt), 64'd6);

        // x0 writes: float x0 is written, integer x0 only acknowledged.
        p_rd[REQ_FPU] = 5'd0; p_data[REQ_FPU] = 32'h1234_5678; p_f[REQ_FPU] = 1'b1;
        drive_cycle(1'b1, 3'b010);
        p_rd[REQ_ALU] = 5'd0; p_data[REQ_ALU] = 32'h0BAD_F00D; p_f[REQ_ALU] = 1'b0;
        drive_cycle(1'b1, 3'b001);
        drive_cycle(1'b1, 3'b000);

        // Stall: mem waits three disabled cycles, then is granted.
        p_rd[REQ_MEM] = 5'd17; p_data[REQ_MEM] = 32'hCAFE_0017; p_f[REQ_MEM] = 1'b0;
        for (int k = 0; k < 3; k++) drive_cycle(1'b0, 3'b100);
        drive_cycle(1'b1, 3'b100);
        drive_cycle(1'b1, 3'b000);

        // Reset asserted while a granted write is on the port.
        p_rd[REQ_ALU] = 5'd7; p_data[REQ_ALU] = 32'h7777_0007;
        drive_cycle(1'b1, 3'b001);
        @(posedge clk);
        #3 rstn = 1'b0;
        model_reset();
        #1;
        check("midrst_completed", 64'(completed), 64'd0);
        check("midrst_strobes", {62'd0, reg_w_enable, freg_w_enable}, 64'd0);
        check("midrst_dest_data", {27'd0, reg_w_dest, reg_w_data}, 64'd0);
        check("midrst_id_cnt", {46'd0, completed_id, conflict_cnt}, 64'd0);
        drive_cycle(1'b1, 3'b111);
        drive_cycle(1'b1, 3'b111);
        @(posedge clk);
        #2 rstn = 1'b1;
        drive_cycle(1'b1, 3'b110);
        check("first_after_rst", 64'(last_win), 64'(REQ_FPU));

        // Long contention: the 2-bit counter saturates at 3.
        for (int k = 0; k < 8; k++) drive_cycle(1'b1, 3'b111);
        drive_cycle(1'b1, 3'b000);
        check("cnt2_sat", 64'(d2_cnt), 64'd3);

        // Randomised requesters that hold payload until accepted.
        pend = '0;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]   = 1'b1;
                    p_rd[i]   = 5'($urandom);
                    p_data[i] = $urandom;
                    p_f[i]    = 1'($urandom);
                end
            end
            drive_cycle($urandom_range(0, 3) != 0, pend);
            if (last_win >= 0) pend[last_win] = 1'b0;
        end
        drive_cycle(1'b0, 3'b000);
        drive_cycle(1'b0, 3'b000);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
